// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the transmit FSM state type, the register offsets within the
// three-word window, and the bit positions of the STATUS and CTRL fields.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Byte offsets of the registers relative to the window base
  localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;

  // STATUS field positions
  localparam int STAT_FULL_BIT   = 0;
  localparam int STAT_EMPTY_BIT  = 1;
  localparam int STAT_ACTIVE_BIT = 2;
  localparam int STAT_OVF_BIT    = 3;
  localparam int STAT_CNT_LSB    = 4;
  localparam int STAT_CNT_MSB    = 7;

  // CTRL field positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_CLR_OVF_BIT = 1;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered occupancy count and show-ahead read data.
// Latency: a pushed entry is visible on dout/empty one cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; pop on empty is ignored.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop_ok;
  logic w_push_ok;

  // A pop frees a slot in the same cycle, so a push on a full FIFO still lands
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and a 3-register bus window.
// Latency: byte written on edge N is popped on N+1 (when enabled and idle); tx falls after N+1.
// Backpressure: writes to a full FIFO (with no same-cycle pop) are dropped and set sticky overflow.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        busy
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic w_hit_txdata;
  logic w_hit_status;
  logic w_hit_ctrl;
  logic w_wr_txdata;
  logic w_wr_ctrl;

  // FIFO side
  logic [7:0]       w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_pop;
  logic             w_push_ok;
  logic [3:0]       w_cnt_field;
  logic             w_unused;

  // Transmitter state
  tx_state_t         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_busy;
  logic              r_enable;
  logic              r_overflow;

  assign w_hit_txdata = (dataadr == BASE_ADDR + OFS_TXDATA);
  assign w_hit_status = (dataadr == BASE_ADDR + OFS_STATUS);
  assign w_hit_ctrl   = (dataadr == BASE_ADDR + OFS_CTRL);
  assign w_wr_txdata  = memwrite && w_hit_txdata;
  assign w_wr_ctrl    = memwrite && w_hit_ctrl;

  // Only the low data byte is ever consumed from the bus
  assign w_unused = ^writedata[31:8];

  // Pop when a new frame may begin: from IDLE, or at the last cycle of a stop bit
  assign w_pop = r_enable && !w_fifo_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && (r_baud == '0)));

  // Mirrors the FIFO acceptance rule so overflow and busy see the same decision
  assign w_push_ok   = w_wr_txdata && (!w_fifo_full || w_pop);
  assign w_count_nxt = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  assign w_cnt_field = 4'(w_fifo_count);

  assign tx   = r_tx;
  assign busy = r_busy;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_wr_txdata),
    .pop   (w_pop),
    .din   (writedata[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  // CTRL enable and sticky overflow; a CTRL write may set enable and clear overflow together
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= writedata[CTRL_EN_BIT];
      end
      if (w_wr_txdata && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (w_wr_ctrl && writedata[CTRL_CLR_OVF_BIT]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Frame sequencer: start, 8 data bits LSB first, stop; tx and busy registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_dout;
            r_baud  <= BAUD_LOAD;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end else begin
            r_busy <= (w_count_nxt != '0);
          end
        end
        ST_START: begin
          if (r_baud == '0) begin
            r_baud    <= BAUD_LOAD;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_baud == '0) begin
            r_baud <= BAUD_LOAD;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        ST_STOP: begin
          if (r_baud == '0) begin
            if (w_pop) begin
              r_shift <= w_fifo_dout;
              r_baud  <= BAUD_LOAD;
              r_tx    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= ST_START;
            end else begin
              r_tx    <= 1'b1;
              r_busy  <= (w_count_nxt != '0);
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud - 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register read mux; TXDATA and unmapped addresses read as zero
  always_comb begin
    readdata = '0;
    if (w_hit_status) begin
      readdata[STAT_FULL_BIT]              = w_fifo_full;
      readdata[STAT_EMPTY_BIT]             = w_fifo_empty;
      readdata[STAT_ACTIVE_BIT]            = (r_state != ST_IDLE);
      readdata[STAT_OVF_BIT]               = r_overflow;
      readdata[STAT_CNT_MSB:STAT_CNT_LSB]  = w_cnt_field;
    end else if (w_hit_ctrl) begin
      readdata[CTRL_EN_BIT] = r_enable;
    end
  end

endmodule
